// File: rtl/sao_pkg.sv
// Shared constants and FSM state type for the SAO frame reader.
package sao_pkg;

    localparam int unsigned FRAME_W = 128;
    localparam int unsigned FRAME_H = 128;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned PIX_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sao_out_fifo.sv
// Two-entry output FIFO; head entry is presented combinationally from storage.
module sao_out_fifo #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/sao_frame_reader.sv
// Streams one raster-order frame from SRAM into a 2-entry output FIFO per start pulse.
// Optional checksum output enabled by SAO_READER_CHECKSUM_EN.
module sao_frame_reader #(
    parameter int unsigned FRAME_W = sao_pkg::FRAME_W,
    parameter int unsigned FRAME_H = sao_pkg::FRAME_H,
    parameter int unsigned ADDR_W  = sao_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [7:0]        sram_q,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
`ifdef SAO_READER_CHECKSUM_EN
   ,output logic [15:0]       checksum
`endif
);

    import sao_pkg::*;

    localparam int unsigned N_PIX = FRAME_W * FRAME_H;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_pend;
    logic               r_pend_last;
    logic               r_busy;
    logic               r_done;
    logic [PIX_W:0]     w_head;
    logic               w_full;
    logic               w_empty;
    logic [1:0]         w_count;
    logic               w_pop;
    logic               w_addr_last;
    logic [2:0]         w_occ;
    logic               w_rd_issue_c;

    assign w_pop       = !w_empty && dout_ready;
    assign w_addr_last = (r_addr == ADDR_W'(N_PIX - 1));
    // Entries that will occupy the FIFO once this edge's pop and in-flight read settle.
    assign w_occ       = {1'b0, w_count} + 3'(r_pend) - 3'(w_pop);
    assign w_rd_issue_c = !reset && (r_state == READ) && !w_full && (w_occ < 3'd2);

    sao_out_fifo #(
        .WIDTH (PIX_W + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_pend),
        .i_wdata ({r_pend_last, sram_q}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = READ;
            READ:    if (w_rd_issue_c && w_addr_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_pop && w_head[PIX_W]) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read counter saturates at the last address; it restarts only on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pend      <= w_rd_issue_c;
            r_pend_last <= w_rd_issue_c && w_addr_last;
            r_busy      <= (w_state_nxt == READ) || (w_state_nxt == DRAIN);
            r_done      <= (w_state_nxt == DONE);
            if ((r_state == IDLE) && start) begin
                r_addr <= '0;
            end else if (w_rd_issue_c && !w_addr_last) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

`ifdef SAO_READER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= 16'd0;
        end else if ((r_state == IDLE) && start) begin
            r_checksum <= 16'd0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + 16'(w_head[PIX_W-1:0]);
        end
    end

    assign checksum = r_checksum;
`endif

    assign sram_cen   = !w_rd_issue_c;
    assign sram_wen   = 1'b1;
    assign sram_a     = r_addr;
    assign dout       = w_head[PIX_W-1:0];
    assign dout_valid = !w_empty;
    assign dout_last  = !w_empty && w_head[PIX_W];
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: doc/sao_frame_reader.md
SAO_FRAME_READER -- requirements
Module: sao_frame_reader

Interface
REQ-001 Parameter FRAME_W, 128, pixels per frame row.
REQ-002 Parameter FRAME_H, 128, frame rows.
REQ-003 Parameter ADDR_W, 14, SRAM address width; SHALL satisfy 2^ADDR_W = FRAME_W*FRAME_H.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse from the SAO stage's finish; begins one frame readout.
REQ-007 sram_cen  output  1  SRAM chip enable, active-low.
REQ-008 sram_wen  output  1  SRAM write enable, active-low; SHALL be tied to 1 (read only).
REQ-009 sram_a  output  ADDR_W  SRAM read address.
REQ-010 sram_q  input  8  SRAM read data, valid one cycle after the address is accepted with sram_cen=0.
REQ-011 dout  output  8  output pixel.
REQ-012 dout_valid  output  1  dout holds a valid pixel.
REQ-013 dout_ready  input  1  downstream accepts; a transfer occurs when dout_valid and dout_ready are both 1.
REQ-014 dout_last  output  1  asserted with the final pixel (address 2^ADDR_W-1).
REQ-015 busy  output  1  high from the cycle after an accepted start until done.
REQ-016 done  output  1  one-cycle pulse after the last transfer.

Function
REQ-017 States SHALL be IDLE, READ, DRAIN and DONE.
REQ-018 IDLE->READ on start; READ->DRAIN after issuing address 2^ADDR_W-1; DRAIN->DONE on the dout_last transfer; DONE->IDLE after one cycle.
REQ-019 Read order SHALL be raster: address = y*FRAME_W + x, starting at 0 and incrementing by 1.
REQ-020 The read counter SHALL NOT wrap; no address SHALL be issued outside READ.
REQ-021 Read data SHALL be captured into a 2-entry output FIFO; dout, dout_valid and dout_last SHALL be driven from the FIFO head.
REQ-022 A read SHALL be issued (sram_cen=0) only when FIFO occupancy plus reads in flight is less than 2, so that no read data is ever dropped.
REQ-023 With dout_ready held at 1, the block SHALL sustain one pixel per cycle after a first-pixel latency of 2 cycles from start.
REQ-024 dout and dout_last SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-025 start SHALL be ignored while busy=1 or the state is DONE.
REQ-026 A full frame with no backpressure SHALL complete, with done asserted, exactly 2^ADDR_W+2 cycles after start.
REQ-027 sram_cen SHALL be 1 whenever no read is being issued.

Reset
REQ-028 Reset SHALL return the block to IDLE, flush the FIFO and clear the read counter.
REQ-029 Reset values SHALL be: sram_cen=1, sram_wen=1, sram_a=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; sram_q returned on the cycle after reset SHALL be discarded.

Configuration
REQ-031 Macro SAO_READER_CHECKSUM_EN defined: the block SHALL add output checksum[15:0].
REQ-032 With the macro, checksum SHALL be the sum modulo 65536 of all transferred pixels; it SHALL clear on an accepted start and be final and held from the done cycle until the next accepted start.
REQ-033 Macro undefined: the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 Package sao_pkg SHALL hold the FSM state enum, FRAME_W, FRAME_H, ADDR_W and the pixel width (8).
REQ-035 The 2-entry FIFO SHALL be a sub-module named sao_out_fifo (parameterised width, with full, empty and count).

Verification
REQ-036 SRAM preloaded with mem[a] = a[7:0], dout_ready=1, start pulse -> 16384 pixels in order 0,1,...,255,0,...; dout_last only on the 16384th pixel; done exactly 16386 cycles after start.
REQ-037 Same preload, dout_ready toggling 1/0 every cycle -> identical pixel sequence with no loss or duplication; dout held stable during each stall.
REQ-038 dout_ready=0 for 100 cycles after start -> at most 2 reads issued; the first accepted pixel = 0x00 and the second = 0x01.
REQ-039 Second start pulse at cycle 500 of a frame -> ignored; a single frame of 16384 pixels and a single done pulse.
REQ-040 Reset asserted at pixel 1000, then start -> new frame begins at address 0 with no stale pixel; after reset all outputs equal their reset values.
REQ-041 With SAO_READER_CHECKSUM_EN and all memory = 0xFF -> checksum = 16384*255 mod 65536 = 0xC000 at done.
